// File: rtl/hex_decimal_display.sv
// hex_decimal_display
//   Drives eight seven-segment digits with the decimal form of a 32-bit word.
//   A word is accepted on a valid/ready handshake. It is converted by a
//   sequential shift-add-3 (double-dabble) engine over 32 cycles, and the
//   result is latched into registered, active-low segment outputs.
//
// Parameters
//   SIGNED       1: two's-complement operand, sign on HEX7, 7 magnitude digits
//                0: unsigned operand, 8 digits
//   BLANK_ZEROS  1: leading zeros blanked (HEX0 always shown)
//
// Ports
//   CLK          clock, rising edge
//   reset        asynchronous reset, active low
//   out_valid    upstream word present on value
//   value[31:0]  word to display, sampled only on accept
//   ready        block can accept (accept = out_valid && ready at an edge)
//   done         one-cycle pulse on the edge the HEX outputs update
//   HEX0..HEX7   segment patterns gfedcba, active low, HEX0 = least significant
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a word, ready=1
// CONV  | one double-dabble shift per cycle, shift counter 0..31
// SHOW  | final BCD valid; load HEX registers and pulse done
module hex_decimal_display #(
   parameter bit SIGNED      = 1'b1,
   parameter bit BLANK_ZEROS = 1'b1
) (
   input  logic        CLK,
   input  logic        reset,
   input  logic        out_valid,
   input  logic [31:0] value,
   output logic        ready,
   output logic        done,
   output logic [6:0]  HEX0,
   output logic [6:0]  HEX1,
   output logic [6:0]  HEX2,
   output logic [6:0]  HEX3,
   output logic [6:0]  HEX4,
   output logic [6:0]  HEX5,
   output logic [6:0]  HEX6,
   output logic [6:0]  HEX7
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      SHOW = 2'd2
   } state_t;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_MINUS = 7'b0111111;
   localparam logic [6:0] SEG_E     = 7'b0000110;
   localparam logic [6:0] SEG_ZERO  = 7'b1000000;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = SEG_E;
      endcase
      return s;
   endfunction

   state_t            state_q, state_d;
   logic [4:0]        cnt_q, cnt_d;
   logic              neg_q, neg_d;
   logic [31:0]       mag_q, mag_d;
   logic [39:0]       bcd_q, bcd_d;
   logic [7:0][6:0]   hex_q, hex_d;
   logic              done_q, done_d;

   logic [39:0]       bcd_adj;
   logic              overflow;
   logic [7:0][6:0]   disp;
   logic              seen_nz;
   logic [3:0]        dig;

   // Add-3 correction applied to every digit before each shift.
   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < 10; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) begin
            bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
         end
      end
   end

   // Signed mode only has 7 magnitude digits, so digit 7 counts as overflow.
   assign overflow = SIGNED ? (|bcd_q[39:28]) : (|bcd_q[39:32]);

   // Segment image built from the finished BCD, used only in SHOW.
   always_comb begin
      disp    = {8{SEG_BLANK}};
      seen_nz = 1'b0;
      dig     = 4'd0;
      for (int i = 7; i >= 0; i--) begin
         dig = bcd_q[4*i +: 4];
         if (SIGNED && (i == 7)) begin
            disp[i] = neg_q ? SEG_MINUS : SEG_BLANK;
         end else begin
            seen_nz = seen_nz | (dig != 4'd0);
            if (!BLANK_ZEROS || seen_nz || (i == 0)) begin
               disp[i] = seg7(dig);
            end
         end
      end
      if (overflow) begin
         disp = {8{SEG_E}};
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      neg_d   = neg_q;
      mag_d   = mag_q;
      bcd_d   = bcd_q;
      hex_d   = hex_q;
      done_d  = 1'b0;
      ready   = 1'b0;
      case (state_q)
         IDLE: begin
            ready = 1'b1;
            if (out_valid) begin
               neg_d   = SIGNED && value[31];
               // 0x80000000 negates to itself, which is the correct magnitude.
               mag_d   = (SIGNED && value[31]) ? (~value + 32'd1) : value;
               bcd_d   = '0;
               cnt_d   = 5'd0;
               state_d = CONV;
            end
         end
         CONV: begin
            {bcd_d, mag_d} = {bcd_adj[38:0], mag_q, 1'b0};
            cnt_d          = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
               state_d = SHOW;
            end
         end
         SHOW: begin
            hex_d   = disp;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= 5'd0;
         neg_q   <= 1'b0;
         mag_q   <= '0;
         bcd_q   <= '0;
         hex_q   <= {{7{SEG_BLANK}}, SEG_ZERO};
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         neg_q   <= neg_d;
         mag_q   <= mag_d;
         bcd_q   <= bcd_d;
         hex_q   <= hex_d;
         done_q  <= done_d;
      end
   end

   assign done = done_q;
   assign HEX0 = hex_q[0];
   assign HEX1 = hex_q[1];
   assign HEX2 = hex_q[2];
   assign HEX3 = hex_q[3];
   assign HEX4 = hex_q[4];
   assign HEX5 = hex_q[5];
   assign HEX6 = hex_q[6];
   assign HEX7 = hex_q[7];

endmodule

// File: tb/tb_hex_decimal_display.sv
module tb_hex_decimal_display;

   localparam logic [6:0] B  = 7'b1111111;
   localparam logic [6:0] MN = 7'b0111111;
   localparam logic [6:0] E  = 7'b0000110;
   localparam logic [6:0] D0 = 7'b1000000;
   localparam logic [6:0] D1 = 7'b1111001;
   localparam logic [6:0] D2 = 7'b0100100;
   localparam logic [6:0] D3 = 7'b0110000;
   localparam logic [6:0] D4 = 7'b0011001;
   localparam logic [6:0] D9 = 7'b0010000;
   localparam logic [6:0] SEGT [10] = '{7'b1000000, 7'b1111001, 7'b0100100,
      7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000};
   localparam logic [55:0] RST_HEX = {B, B, B, B, B, B, B, D0};

   logic        CLK = 1'b0;
   logic        reset = 1'b0;
   logic        out_valid = 1'b0;
   logic [31:0] value = 32'd0;
   logic        ready_s, done_s, ready_u, done_u;
   logic [6:0]  hs0, hs1, hs2, hs3, hs4, hs5, hs6, hs7;
   logic [6:0]  hu0, hu1, hu2, hu3, hu4, hu5, hu6, hu7;
   logic [55:0] hex_s, hex_u;

   int vectors = 0;
   int miscompares = 0;

   always #5 CLK = ~CLK;

   // Signed with blanking, and unsigned without blanking, fed the same words.
   hex_decimal_display #(.SIGNED(1'b1), .BLANK_ZEROS(1'b1)) u_s (
      .CLK(CLK), .reset(reset), .out_valid(out_valid), .value(value),
      .ready(ready_s), .done(done_s),
      .HEX0(hs0), .HEX1(hs1), .HEX2(hs2), .HEX3(hs3),
      .HEX4(hs4), .HEX5(hs5), .HEX6(hs6), .HEX7(hs7));

   hex_decimal_display #(.SIGNED(1'b0), .BLANK_ZEROS(1'b0)) u_u (
      .CLK(CLK), .reset(reset), .out_valid(out_valid), .value(value),
      .ready(ready_u), .done(done_u),
      .HEX0(hu0), .HEX1(hu1), .HEX2(hu2), .HEX3(hu3),
      .HEX4(hu4), .HEX5(hu5), .HEX6(hu6), .HEX7(hu7));

   assign hex_s = {hs7, hs6, hs5, hs4, hs3, hs2, hs1, hs0};
   assign hex_u = {hu7, hu6, hu5, hu4, hu3, hu2, hu1, hu0};

   task automatic chk(input string name, input logic [55:0] act, input logic [55:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Decimal rendering straight from the arithmetic value.
   function automatic logic [55:0] model_disp(input logic [31:0] v, input bit sgn, input bit blk);
      longint     mag, p;
      bit         neg;
      logic [55:0] r;
      int         ndig;
      neg = sgn && v[31];
      mag = neg ? (64'sd4294967296 - longint'(v)) : longint'(v);
      if (mag > (sgn ? 64'sd9999999 : 64'sd99999999)) return {8{E}};
      r    = {8{B}};
      ndig = sgn ? 7 : 8;
      p    = 1;
      for (int i = 0; i < ndig; i++) begin
         if (!blk || i == 0 || mag >= p) r[7*i +: 7] = SEGT[int'((mag / p) % 10)];
         p = p * 10;
      end
      if (neg) r[55:49] = MN;
      return r;
   endfunction

   // Transaction-level timing model: display appears 33 edges after accept.
   int          busy = 0;
   logic [31:0] pend = 32'd0;
   logic        m_done = 1'b0;
   logic [55:0] m_hex_s = RST_HEX;
   logic [55:0] m_hex_u = RST_HEX;
   bit          chk_en = 1'b0;

   always @(posedge CLK or negedge reset) begin
      if (!reset) begin
         busy    <= 0;
         m_done  <= 1'b0;
         m_hex_s <= RST_HEX;
         m_hex_u <= RST_HEX;
      end else begin
         m_done <= 1'b0;
         if (busy > 0) begin
            busy <= busy - 1;
            if (busy == 1) begin
               m_hex_s <= model_disp(pend, 1'b1, 1'b1);
               m_hex_u <= model_disp(pend, 1'b0, 1'b0);
               m_done  <= 1'b1;
            end
         end else if (out_valid) begin
            pend <= value;
            busy <= 33;
         end
      end
   end

   always @(negedge CLK) begin
      if (chk_en) begin
         chk("ready_s", {55'd0, ready_s}, {55'd0, busy == 0});
         chk("done_s",  {55'd0, done_s},  {55'd0, m_done});
         chk("hex_s",   hex_s, m_hex_s);
         chk("ready_u", {55'd0, ready_u}, {55'd0, busy == 0});
         chk("done_u",  {55'd0, done_u},  {55'd0, m_done});
         chk("hex_u",   hex_u, m_hex_u);
      end
   end

   task automatic send(input logic [31:0] v);
      bit got;
      got = 1'b0;
      @(posedge CLK); #1;
      out_valid = 1'b1;
      value     = v;
      for (int n = 0; n < 100; n++) begin
         @(negedge CLK);
         if (ready_s) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) chk("accept_timeout", 56'd0, 56'd1);
      @(posedge CLK); #1;
      out_valid = 1'b0;
      value     = $urandom;
   endtask

   task automatic wait_done();
      bit seen;
      seen = 1'b0;
      for (int n = 0; n < 40; n++) begin
         @(negedge CLK);
         if (done_s) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) chk("done_timeout", 56'd0, 56'd1);
   endtask

   initial begin
      logic [31:0] v;

      chk("model_1234", model_disp(32'd1234, 1'b1, 1'b1), {B, B, B, B, D1, D2, D3, D4});
      chk("model_m123", model_disp(32'hFFFFFF85, 1'b1, 1'b1), {MN, B, B, B, B, D1, D2, D3});
      chk("model_ovf",  model_disp(32'h80000000, 1'b1, 1'b1), {8{E}});

      reset = 1'b0;
      repeat (3) @(posedge CLK);
      chk_en = 1'b1;
      @(negedge CLK);
      chk("rst_hex", hex_s, RST_HEX);
      @(posedge CLK); #1;
      reset = 1'b1;
      repeat (10) @(posedge CLK);
      @(negedge CLK);
      chk("idle_hex", hex_s, RST_HEX);
      chk("idle_ready", {55'd0, ready_s}, 56'd1);

      send(32'd1234);
      wait_done();
      chk("lit_1234_s", hex_s, {B, B, B, B, D1, D2, D3, D4});
      chk("lit_1234_u", hex_u, {D0, D0, D0, D0, D1, D2, D3, D4});

      send(32'hFFFFFF85);
      wait_done();
      chk("lit_m123", hex_s, {MN, B, B, B, B, D1, D2, D3});

      send(32'd9999999);
      wait_done();
      chk("lit_9999999", hex_s, {B, D9, D9, D9, D9, D9, D9, D9});

      send(32'd10000000);
      wait_done();
      chk("lit_ovf_10M", hex_s, {8{E}});

      send(32'h80000000);
      wait_done();
      chk("lit_ovf_min", hex_s, {8{E}});

      send(32'd99999999);
      wait_done();
      chk("lit_u_8nines", hex_u, {8{D9}});

      send(32'd100000000);
      wait_done();
      chk("lit_u_ovf", hex_u, {8{E}});

      send(32'd0);
      wait_done();
      chk("lit_zero", hex_s, {B, B, B, B, B, B, B, D0});

      // Continuous valid with a new word every cycle.
      @(posedge CLK); #1;
      out_valid = 1'b1;
      repeat (34 * 3 + 5) begin
         value = $urandom;
         @(posedge CLK); #1;
      end
      out_valid = 1'b0;
      repeat (40) @(posedge CLK);

      // Reset in the middle of a conversion.
      send(32'd555);
      repeat (14) @(posedge CLK);
      #1 reset = 1'b0;
      @(negedge CLK);
      chk("midrst_hex", hex_s, RST_HEX);
      chk("midrst_done", {55'd0, done_s}, 56'd0);
      repeat (2) @(posedge CLK);
      #1 reset = 1'b1;
      send(32'd7);
      wait_done();
      chk("lit_after_rst", hex_s, {B, B, B, B, B, B, B, 7'b1111000});

      for (int t = 0; t < 30; t++) begin
         case ($urandom_range(0, 3))
            0: v = $urandom;
            1: v = $urandom_range(0, 9999);
            2: v = 32'd0 - $urandom_range(0, 9999999);
            default: v = $urandom_range(0, 99999999);
         endcase
         send(v);
         repeat ($urandom_range(0, 40)) @(posedge CLK);
      end
      repeat (40) @(posedge CLK);
      @(negedge CLK);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/hex_decimal_display.md
# hex_decimal_display

Output-stage display driver for the board's eight seven-segment digits, downstream of the processor's output path. It accepts a 32-bit word via a valid/ready handshake and converts it to decimal with a sequential shift-add-3 (double-dabble) engine. It then drives HEX7..HEX0 with registered, active-low segment patterns, including sign, leading-zero blanking and overflow indication. The displayed value persists until the next accepted word or reset.

## Interface
- SIGNED, 1: 1 = operand is two's complement (sign on HEX7, 7 magnitude digits); 0 = unsigned, 8 digits.
- BLANK_ZEROS, 1: 1 = leading zeros blanked; 0 = all digit positions shown.
- CLK  input  1  single clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- out_valid  input  1  upstream has a word on value.
- value  input  32  word to display; sampled only on accept.
- ready  output  1  block can accept; accept = out_valid && ready at a rising edge.
- done  output  1  one-cycle pulse on the edge the HEX outputs update.
- HEX0..HEX7  output  7 each  segment patterns, active-low, bit order gfedcba; HEX0 = least significant digit.

## Operation
- Encodings: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, minus=0111111, E=0000110, blank=1111111.
- FSM states: IDLE, CONV, SHOW.
  - IDLE: ready=1. On accept: latch negative flag (SIGNED && value[31]); latch magnitude (two's-complement negate if negative, else value, as 32-bit unsigned); clear the 40-bit BCD register (10 digits); set shift counter to 0; go to CONV.
  - CONV: one shift per cycle, 32 cycles. Each cycle: add 3 to every BCD digit ≥ 5, then shift {BCD, magnitude} left by 1. After the 32nd shift, go to SHOW.
  - SHOW: single cycle. Compute overflow, load HEX registers, pulse done, return to IDLE.
- Overflow rule:
  - SIGNED=1: any of BCD digits 9..7 nonzero (magnitude > 9,999,999). This includes 0x80000000 (2,147,483,648).
  - SIGNED=0: digit 9 or 8 nonzero (> 99,999,999).
  - On overflow, all eight outputs show E.
- Normal display, SIGNED=1:
  - HEX6..HEX0 show BCD digits 6..0.
  - HEX7 shows minus if negative, else blank. Minus is fixed at HEX7 and is not adjacent to the leading digit.
- Normal display, SIGNED=0: HEX7..HEX0 show digits 7..0.
- Blanking (BLANK_ZEROS=1): digit positions above the most significant nonzero digit are blank. HEX0 is always shown, so value 0 shows a single 0.
- Negative zero is impossible; value 0 never shows minus.
- ready=0 throughout CONV and SHOW. out_valid while ready=0 is not accepted; upstream holds value and out_valid until accepted.

## Timing
- Reset (asynchronous assert, any state, including mid-conversion):
  - state=IDLE, ready=1, done=0, conversion aborted.
  - HEX0=1000000 (0), HEX1..HEX7=blank.
  - Reset leaves no trace of a partial conversion.
- Accept at edge k → CONV during cycles k+1..k+32 (shift counter 0..31) → SHOW state.
- At edge k+33: HEX outputs update, done=1 for one cycle, ready returns to 1.
- Latency: 33 edges accept-to-display. Earliest next accept is edge k+34.
- out_valid held continuously: one word accepted every 34 cycles.
- Between updates, HEX outputs are stable. Changes to value or out_valid have no effect outside accept edges.

## Test plan
- Reset then release, no stimulus → HEX0=1000000, HEX1..7=1111111, ready=1, done=0 indefinitely.
- Accept value=1234 (SIGNED=1, BLANK_ZEROS=1) → ready low for exactly 33 cycles; at edge k+33 done pulses once; HEX3..0 = 1, 2, 3, 4 patterns; HEX7..4 blank.
- Accept 0xFFFFFF85 (−123) → HEX7=0111111, HEX6..3 blank, HEX2..0 = 1, 2, 3. Then accept 9999999 → HEX6..0 all 0010000, HEX7 blank.
- Overflow cases, SIGNED=1: accept 10000000 → all HEX=0000110; accept 0x80000000 → all HEX=0000110.
  - With SIGNED=0, 99999999 shows eight 9s and 100000000 shows all E.
- Hold out_valid high with value changing every cycle → only words present at accept edges (k, k+34, k+68) are displayed. No accepts occur while ready=0.
- Assert reset at cycle k+15 of a conversion of 555 → HEX returns to reset pattern immediately, no done pulse. Accept 7 after release → displays 7 after 33 edges.
